// File: rtl/dram_cmd_scheduler.sv
// Inter-bank DRAM command arbiter: REF > RD/WR > PRE > ACT with round-robin per class and tRRD/tCCD/tWTR/tRTW spacing.
// Define SCHED_TFAW_EN to add the four-activate window (tFAW); otherwise t_faw is accepted but ignored.
module dram_cmd_scheduler #(
  parameter int NUM_BANKS = 4,
  parameter int BA_WIDTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_BANKS-1:0] act_req,
  input  logic [NUM_BANKS-1:0] rd_req,
  input  logic [NUM_BANKS-1:0] wr_req,
  input  logic [NUM_BANKS-1:0] pre_req,
  input  logic [NUM_BANKS-1:0] ref_req,
  output logic [NUM_BANKS-1:0] act_gnt,
  output logic [NUM_BANKS-1:0] rd_gnt,
  output logic [NUM_BANKS-1:0] wr_gnt,
  output logic [NUM_BANKS-1:0] pre_gnt,
  output logic [NUM_BANKS-1:0] ref_gnt,
  input  logic [3:0]           t_rrd,
  input  logic [3:0]           t_ccd,
  input  logic [3:0]           t_wtr,
  input  logic [3:0]           t_rtw,
  input  logic [5:0]           t_faw,
  output logic                 cmd_valid,
  output logic [2:0]           cmd_type,
  output logic [BA_WIDTH-1:0]  cmd_bank
);

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } cmd_t;

  logic [BA_WIDTH-1:0] ref_ptr_reg, col_ptr_reg, pre_ptr_reg, act_ptr_reg;
  logic [3:0]          rrd_cnt_reg, ccd_cnt_reg, wtr_cnt_reg, rtw_cnt_reg;
  logic [BA_WIDTH:0]   ref_pick, col_pick, pre_pick, act_pick;
  logic [NUM_BANKS-1:0] col_elig, act_elig;
  logic                rd_ok, wr_ok, act_ok, faw_block;
  cmd_t                gnt_type;
  logic [BA_WIDTH-1:0] gnt_bank;

  // Returns {found, bank}: first requesting bank at or after ptr, wrapping at NUM_BANKS.
  function automatic logic [BA_WIDTH:0] rr_pick(input logic [NUM_BANKS-1:0] req,
                                                input logic [BA_WIDTH-1:0]  ptr);
    logic                found;
    logic [BA_WIDTH-1:0] idx;
    logic [BA_WIDTH-1:0] cand;
    int                  b;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      b    = (int'(ptr) + k) % NUM_BANKS;
      cand = BA_WIDTH'(b);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [BA_WIDTH-1:0] ptr_after(input logic [BA_WIDTH-1:0] b);
    return (b == BA_WIDTH'(NUM_BANKS - 1)) ? '0 : b + 1'b1;
  endfunction

  function automatic logic [3:0] load4(input logic [3:0] t);
    return (t == 4'd0) ? 4'd0 : t - 4'd1;
  endfunction

  function automatic logic [3:0] dec4(input logic [3:0] c);
    return (c == 4'd0) ? 4'd0 : c - 4'd1;
  endfunction

`ifdef SCHED_TFAW_EN
  // Each slot holds the remaining window of one recent ACT; all four busy means the window is full.
  logic [3:0] faw_idle;
  logic [1:0] faw_slot;

  always_comb begin
    faw_slot = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (faw_idle[k]) faw_slot = 2'(k);
    end
  end

  assign faw_block = (faw_idle == 4'b0000);

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_faw
    logic [5:0] age_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        age_reg <= '0;
      end else if (gnt_type == CMD_ACT && faw_slot == 2'(gi)) begin
        age_reg <= (t_faw == 6'd0) ? 6'd0 : t_faw - 6'd1;
      end else if (age_reg != 6'd0) begin
        age_reg <= age_reg - 6'd1;
      end
    end
    assign faw_idle[gi] = (age_reg == 6'd0);
  end
`else
  logic unused_tfaw;
  assign faw_block   = 1'b0;
  assign unused_tfaw = ^t_faw;
`endif

  assign rd_ok    = (ccd_cnt_reg == 4'd0) && (wtr_cnt_reg == 4'd0);
  assign wr_ok    = (ccd_cnt_reg == 4'd0) && (rtw_cnt_reg == 4'd0);
  assign act_ok   = (rrd_cnt_reg == 4'd0) && !faw_block;
  assign col_elig = (rd_req & {NUM_BANKS{rd_ok}}) | (wr_req & {NUM_BANKS{wr_ok}});
  assign act_elig = act_req & {NUM_BANKS{act_ok}};

  always_comb begin
    ref_pick = rr_pick(ref_req, ref_ptr_reg);
    col_pick = rr_pick(col_elig, col_ptr_reg);
    pre_pick = rr_pick(pre_req, pre_ptr_reg);
    act_pick = rr_pick(act_elig, act_ptr_reg);
    gnt_type = CMD_NOP;
    gnt_bank = '0;
    act_gnt  = '0;
    rd_gnt   = '0;
    wr_gnt   = '0;
    pre_gnt  = '0;
    ref_gnt  = '0;
    if (!rst) begin
      if (ref_pick[BA_WIDTH]) begin
        gnt_type = CMD_REF;
        gnt_bank = ref_pick[BA_WIDTH-1:0];
      end else if (col_pick[BA_WIDTH]) begin
        gnt_bank = col_pick[BA_WIDTH-1:0];
        // A bank asking for both directions gets the read when reads are allowed.
        gnt_type = (rd_req[gnt_bank] && rd_ok) ? CMD_RD : CMD_WR;
      end else if (pre_pick[BA_WIDTH]) begin
        gnt_type = CMD_PRE;
        gnt_bank = pre_pick[BA_WIDTH-1:0];
      end else if (act_pick[BA_WIDTH]) begin
        gnt_type = CMD_ACT;
        gnt_bank = act_pick[BA_WIDTH-1:0];
      end
    end
    case (gnt_type)
      CMD_ACT: act_gnt[gnt_bank] = 1'b1;
      CMD_RD:  rd_gnt[gnt_bank]  = 1'b1;
      CMD_WR:  wr_gnt[gnt_bank]  = 1'b1;
      CMD_PRE: pre_gnt[gnt_bank] = 1'b1;
      CMD_REF: ref_gnt[gnt_bank] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_ptr_reg <= '0;
      col_ptr_reg <= '0;
      pre_ptr_reg <= '0;
      act_ptr_reg <= '0;
      rrd_cnt_reg <= '0;
      ccd_cnt_reg <= '0;
      wtr_cnt_reg <= '0;
      rtw_cnt_reg <= '0;
      cmd_valid   <= 1'b0;
      cmd_type    <= 3'd0;
      cmd_bank    <= '0;
    end else begin
      rrd_cnt_reg <= dec4(rrd_cnt_reg);
      ccd_cnt_reg <= dec4(ccd_cnt_reg);
      wtr_cnt_reg <= dec4(wtr_cnt_reg);
      rtw_cnt_reg <= dec4(rtw_cnt_reg);
      case (gnt_type)
        CMD_ACT: begin
          act_ptr_reg <= ptr_after(gnt_bank);
          rrd_cnt_reg <= load4(t_rrd);
        end
        CMD_RD: begin
          col_ptr_reg <= ptr_after(gnt_bank);
          ccd_cnt_reg <= load4(t_ccd);
          rtw_cnt_reg <= load4(t_rtw);
        end
        CMD_WR: begin
          col_ptr_reg <= ptr_after(gnt_bank);
          ccd_cnt_reg <= load4(t_ccd);
          wtr_cnt_reg <= load4(t_wtr);
        end
        CMD_PRE: pre_ptr_reg <= ptr_after(gnt_bank);
        CMD_REF: ref_ptr_reg <= ptr_after(gnt_bank);
        default: ;
      endcase
      cmd_valid <= (gnt_type != CMD_NOP);
      cmd_type  <= gnt_type;
      if (gnt_type != CMD_NOP) cmd_bank <= gnt_bank;
    end
  end

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Table-driven bench for dram_cmd_scheduler: per-cycle grant vectors plus a scoreboard for the registered command strobe.
module tb_dram_cmd_scheduler;

  logic       clk;
  logic       rst;
  logic [3:0] act_req, rd_req, wr_req, pre_req, ref_req;
  logic [3:0] act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
  logic [3:0] t_rrd, t_ccd, t_wtr, t_rtw;
  logic [5:0] t_faw;
  logic       cmd_valid;
  logic [2:0] cmd_type;
  logic [1:0] cmd_bank;

  dram_cmd_scheduler #(.NUM_BANKS(4), .BA_WIDTH(2)) dut (
    .clk(clk), .rst(rst),
    .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req), .pre_req(pre_req), .ref_req(ref_req),
    .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .pre_gnt(pre_gnt), .ref_gnt(ref_gnt),
    .t_rrd(t_rrd), .t_ccd(t_ccd), .t_wtr(t_wtr), .t_rtw(t_rtw), .t_faw(t_faw),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_bank(cmd_bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3, PRE = 3'd4, REF = 3'd5;

  typedef struct {
    logic       rst;
    logic [3:0] act, rd, wr, pre, refr;
    logic [3:0] trrd, tccd, twtr, trtw;
    logic [5:0] tfaw;
    logic [2:0] gtype;
    logic [1:0] gbank;
  } vec_t;

  typedef struct {
    logic       valid;
    logic [2:0] ctype;
    logic [1:0] bank;
  } cmd_exp_t;

  vec_t     vecs[$];
  cmd_exp_t sb[$];
  int       checks = 0;
  int       failures = 0;
  logic [3:0] cur_trrd, cur_tccd, cur_twtr, cur_trtw;
  logic [5:0] cur_tfaw;
  logic [1:0] last_bank;

  task automatic set_timing(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                            input logic [3:0] d, input logic [5:0] e);
    cur_trrd = a; cur_tccd = b; cur_twtr = c; cur_trtw = d; cur_tfaw = e;
  endtask

  task automatic add(input logic r, input logic [3:0] a, input logic [3:0] rd, input logic [3:0] wr,
                     input logic [3:0] pre, input logic [3:0] rf, input logic [2:0] gt, input logic [1:0] gb);
    vec_t v;
    v.rst = r; v.act = a; v.rd = rd; v.wr = wr; v.pre = pre; v.refr = rf;
    v.trrd = cur_trrd; v.tccd = cur_tccd; v.twtr = cur_twtr; v.trtw = cur_trtw; v.tfaw = cur_tfaw;
    v.gtype = gt; v.gbank = gb;
    vecs.push_back(v);
  endtask

  // Expected grants packed as {act, rd, wr, pre, ref}.
  function automatic logic [19:0] gnt_vec(input logic [2:0] gt, input logic [1:0] gb);
    logic [19:0] r;
    logic [3:0]  oh;
    r  = '0;
    oh = 4'b0001 << gb;
    case (gt)
      ACT:     r[19:16] = oh;
      RD:      r[15:12] = oh;
      WR:      r[11:8]  = oh;
      PRE:     r[7:4]   = oh;
      REF:     r[3:0]   = oh;
      default: ;
    endcase
    return r;
  endfunction

  task automatic check_invariants(input int row);
    logic [19:0] g, q;
    g = {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt};
    q = {act_req, rd_req, wr_req, pre_req, ref_req};
    checks++;
    if (!$onehot0(g)) begin
      failures++;
      $display("FAIL onehot row %0d: grants=%h required one-hot-or-zero", row, g);
    end
    checks++;
    if ((g & ~q) != 20'd0) begin
      failures++;
      $display("FAIL gnt_without_req row %0d: grants=%h requests=%h", row, g, q);
    end
  endtask

  task automatic check_cmd(input int row);
    cmd_exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({cmd_valid, cmd_type, cmd_bank} !== {e.valid, e.ctype, e.bank}) begin
        failures++;
        $display("FAIL cmd row %0d: got valid=%0b type=%0d bank=%0d required valid=%0b type=%0d bank=%0d",
                 row, cmd_valid, cmd_type, cmd_bank, e.valid, e.ctype, e.bank);
      end
    end
  endtask

  initial begin
    logic [19:0] exp_g, act_g;
    cmd_exp_t    ce;
    rst = 1'b1; act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
    t_rrd = '0; t_ccd = '0; t_wtr = '0; t_rtw = '0; t_faw = '0;
    last_bank = '0;

    // ACT spacing by t_rrd=2 with all four banks requesting.
    set_timing(4'd2, 4'd1, 4'd1, 4'd1, 6'd0);
    add(1, 0, 0, 0, 0, 0, NOP, 0);
    for (int c = 0; c < 8; c++) add(0, 4'hF, 0, 0, 0, 0, (c % 2 == 0) ? ACT : NOP, 2'(c / 2));

    // WR->RD turnaround (t_wtr=5), then RD->WR turnaround (t_rtw=3).
    set_timing(4'd1, 4'd2, 4'd5, 4'd3, 6'd0);
    add(1, 0, 0, 0, 0, 0, NOP, 0);
    add(0, 0, 4'b0100, 4'b0010, 0, 0, WR, 1);
    for (int c = 1; c < 5; c++) add(0, 0, 4'b0100, 0, 0, 0, NOP, 0);
    add(0, 0, 4'b0100, 0, 0, 0, RD, 2);
    add(0, 0, 0, 4'b1000, 0, 0, NOP, 0);
    add(0, 0, 0, 4'b1000, 0, 0, NOP, 0);
    add(0, 0, 0, 4'b1000, 0, 0, WR, 3);
    add(0, 0, 0, 0, 0, 0, NOP, 0);

    // Class priority REF > column > PRE > ACT.
    set_timing(4'd1, 4'd1, 4'd1, 4'd1, 6'd0);
    add(1, 0, 0, 0, 0, 0, NOP, 0);
    add(0, 4'b0100, 4'b0001, 0, 4'b0010, 4'b1000, REF, 3);
    add(0, 4'b0100, 4'b0001, 0, 4'b0010, 0, RD, 0);
    add(0, 4'b0100, 0, 0, 4'b0010, 0, PRE, 1);
    add(0, 4'b0100, 0, 0, 0, 0, ACT, 2);
    add(0, 0, 0, 0, 0, 0, NOP, 0);

    // Column class blocked by t_ccd=3 yields to PRE in the same cycle.
    set_timing(4'd1, 4'd3, 4'd1, 4'd1, 6'd0);
    add(1, 0, 0, 0, 0, 0, NOP, 0);
    add(0, 0, 4'b0011, 0, 4'b0100, 0, RD, 0);
    add(0, 0, 4'b0010, 0, 4'b0100, 0, PRE, 2);
    add(0, 0, 4'b0010, 0, 0, 0, NOP, 0);
    add(0, 0, 4'b0010, 0, 0, 0, RD, 1);
    add(0, 0, 0, 0, 0, 0, NOP, 0);

    // Reset in the middle of a t_ccd=8 window clears pointer and counter.
    set_timing(4'd1, 4'd8, 4'd1, 4'd1, 6'd0);
    add(1, 0, 0, 0, 0, 0, NOP, 0);
    add(0, 0, 4'b0011, 0, 0, 0, RD, 0);
    add(0, 0, 4'b0011, 0, 0, 0, NOP, 0);
    add(0, 0, 4'b0011, 0, 0, 0, NOP, 0);
    add(1, 0, 4'b0011, 0, 0, 0, NOP, 0);
    add(0, 0, 4'b0011, 0, 0, 0, RD, 0);
    add(0, 0, 4'b0011, 0, 0, 0, NOP, 0);

    // t_rrd=0 allows back-to-back ACT; pointer wraps 3 -> 0.
    set_timing(4'd0, 4'd0, 4'd0, 4'd0, 6'd0);
    add(1, 0, 0, 0, 0, 0, NOP, 0);
    add(0, 4'b1010, 0, 0, 0, 0, ACT, 1);
    add(0, 4'b1010, 0, 0, 0, 0, ACT, 3);
    add(0, 4'b1010, 0, 0, 0, 0, ACT, 1);

`ifdef SCHED_TFAW_EN
    // Four-activate window: fifth ACT waits until first-ACT cycle + t_faw.
    set_timing(4'd1, 4'd1, 4'd1, 4'd1, 6'd10);
    add(1, 0, 0, 0, 0, 0, NOP, 0);
    for (int c = 0; c < 11; c++) add(0, 4'hF, 0, 0, 0, 0, (c < 4 || c == 10) ? ACT : NOP, (c < 4) ? 2'(c) : 2'd0);
`endif

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      act_req = vecs[i].act; rd_req = vecs[i].rd; wr_req = vecs[i].wr;
      pre_req = vecs[i].pre; ref_req = vecs[i].refr;
      t_rrd = vecs[i].trrd; t_ccd = vecs[i].tccd; t_wtr = vecs[i].twtr;
      t_rtw = vecs[i].trtw; t_faw = vecs[i].tfaw;
      @(negedge clk);
      exp_g = gnt_vec(vecs[i].gtype, vecs[i].gbank);
      act_g = {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt};
      checks++;
      if (act_g !== exp_g) begin
        failures++;
        $display("FAIL grants row %0d: got %h required %h", i, act_g, exp_g);
      end
      if (i > 0) check_invariants(i);
      check_cmd(i);
      if (vecs[i].rst) begin
        ce.valid = 1'b0; ce.ctype = NOP; ce.bank = 2'd0;
        last_bank = 2'd0;
      end else if (vecs[i].gtype != NOP) begin
        ce.valid = 1'b1; ce.ctype = vecs[i].gtype; ce.bank = vecs[i].gbank;
        last_bank = vecs[i].gbank;
      end else begin
        ce.valid = 1'b0; ce.ctype = NOP; ce.bank = last_bank;
      end
      sb.push_back(ce);
      $display("row %0d rst=%0b act=%b rd=%b wr=%b pre=%b ref=%b -> grants=%h cmd=%0b/%0d/%0d",
               i, rst, act_req, rd_req, wr_req, pre_req, ref_req, act_g, cmd_valid, cmd_type, cmd_bank);
      @(posedge clk); #1;
    end

    rst = 1'b0; act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
    @(negedge clk);
    check_cmd(vecs.size());
    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
